// File: rtl/pe_conv_stream.sv
// Channel-serial convolution PE: accumulates CHANNELS (tile, kernel) beats one tap per cycle
// across all output pixels in parallel, then offers one OUTxOUT tile on a valid/ready port.
module pe_conv_stream #(
    parameter int KERNEL_SIZE       = 3,
    parameter int INPUT_TILE_SIZE   = 4,
    parameter int INPUT_DATA_WIDTH  = 8,
    parameter int KERNEL_DATA_WIDTH = 8,
    parameter int CHANNELS          = 3,
    parameter int ACC_WIDTH         = 29,
    parameter int RELU              = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    output logic in_ready,
    input  logic [INPUT_TILE_SIZE*INPUT_TILE_SIZE*INPUT_DATA_WIDTH-1:0] inpData,
    input  logic [KERNEL_SIZE*KERNEL_SIZE*KERNEL_DATA_WIDTH-1:0] Kernel,
    input  logic flip,
    output logic out_valid,
    input  logic out_ready,
    output logic [(INPUT_TILE_SIZE-KERNEL_SIZE+1)*(INPUT_TILE_SIZE-KERNEL_SIZE+1)*ACC_WIDTH-1:0] outData,
    output logic busy
);
    localparam int K     = KERNEL_SIZE;
    localparam int T     = INPUT_TILE_SIZE;
    localparam int IW    = INPUT_DATA_WIDTH;
    localparam int KW    = KERNEL_DATA_WIDTH;
    localparam int C     = CHANNELS;
    localparam int AW    = ACC_WIDTH;
    localparam int OUT   = T - K + 1;
    localparam int NTAP  = K * K;
    localparam int PW    = IW + KW;
    localparam int TIDXW = (T * T > 1) ? $clog2(T * T) : 1;
    localparam int KIDXW = (NTAP > 1) ? $clog2(NTAP) : 1;
    localparam int CHW   = (C > 1) ? $clog2(C) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                r_state;
    logic [KIDXW-1:0]      r_tap;
    logic [CHW-1:0]        r_chan;
    logic                  r_flip;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_busy;
    logic signed [IW-1:0]  r_tile [T*T];
    logic signed [KW-1:0]  r_kern [NTAP];

    logic                  w_accept;
    logic                  w_clear;
    logic                  w_last_tap;
    logic                  w_final;
    logic [KIDXW-1:0]      w_u;
    logic [KIDXW-1:0]      w_v;
    logic [KIDXW-1:0]      w_widx;
    logic signed [KW-1:0]  w_w;

    assign w_accept   = (r_state == S_IDLE) && in_valid && r_in_ready;
    assign w_clear    = w_accept && (r_chan == '0);
    assign w_last_tap = (r_state == S_MAC) && (r_tap == KIDXW'(NTAP - 1));
    assign w_final    = w_last_tap && (r_chan == CHW'(C - 1));

    // True convolution walks the kernel backwards: w(K-1-u,K-1-v) is flat index NTAP-1-tap.
    assign w_u    = r_tap / KIDXW'(K);
    assign w_v    = r_tap % KIDXW'(K);
    assign w_widx = r_flip ? (KIDXW'(NTAP - 1) - r_tap) : r_tap;
    assign w_w    = r_kern[w_widx];

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_tap       <= '0;
            r_chan      <= '0;
            r_flip      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_tap      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_MAC;
                        if (r_chan == '0) begin
                            r_flip <= flip;
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                S_MAC: begin
                    if (w_last_tap) begin
                        r_tap <= '0;
                        if (w_final) begin
                            r_out_valid <= 1'b1;
                            r_state     <= S_OUT;
                        end else begin
                            r_chan     <= r_chan + 1'b1;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= S_IDLE;
                        end
                    end else begin
                        r_tap <= r_tap + 1'b1;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_chan      <= '0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    // Beat payload is only consumed while in MAC, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < T * T; i++) begin
                r_tile[i] <= inpData[i*IW +: IW];
            end
            for (int i = 0; i < NTAP; i++) begin
                r_kern[i] <= Kernel[i*KW +: KW];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < OUT; gi++) begin : g_row
            for (genvar gj = 0; gj < OUT; gj++) begin : g_col
                localparam int P = gi * OUT + gj;

                logic [TIDXW-1:0]     w_xidx;
                logic signed [IW-1:0] w_x;
                logic signed [PW-1:0] w_prod;
                logic signed [AW-1:0] w_sum;
                logic signed [AW-1:0] w_relu;
                logic signed [AW-1:0] r_acc;
                logic signed [AW-1:0] r_pix;

                assign w_xidx = TIDXW'((gi + int'(w_u)) * T + gj + int'(w_v));
                assign w_x    = r_tile[w_xidx];
                assign w_prod = PW'(w_x) * PW'(w_w);
                assign w_sum  = r_acc + AW'(w_prod);
                assign w_relu = ((RELU != 0) && w_sum[AW-1]) ? '0 : w_sum;

                always_ff @(posedge clk) begin
                    if (!reset) begin
                        r_acc <= '0;
                        r_pix <= '0;
                    end else if (w_clear) begin
                        r_acc <= '0;
                    end else if (r_state == S_MAC) begin
                        r_acc <= w_sum;
                        if (w_final) begin
                            r_pix <= w_relu;
                        end
                    end
                end

                assign outData[P*AW +: AW] = r_pix;
            end
        end
    endgenerate

endmodule

// File: tb/tb_pe_conv_stream.sv
// Directed bench for pe_conv_stream: three instances (C=1, C=1 with ReLU, C=3) driven from a
// vector table plus hand-written stall and mid-tile reset sequences.
module tb_pe_conv_stream;
    localparam int AW   = 29;
    localparam int NDUT = 3;

    typedef struct {
        int                 dut;
        logic [127:0]       tile;
        logic [71:0]        kern;
        logic               flip0;
        logic               flip_rest;
        int                 beats;
        logic [0:3][31:0]   exp;
    } vec_t;

    logic              clk;
    logic              reset;
    logic              in_valid  [NDUT];
    logic              in_ready  [NDUT];
    logic [127:0]      inp_data  [NDUT];
    logic [71:0]       kern      [NDUT];
    logic              flip_s    [NDUT];
    logic              out_valid [NDUT];
    logic              out_ready [NDUT];
    logic [4*AW-1:0]   out_data  [NDUT];
    logic              busy      [NDUT];

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vt [9];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
            pe_conv_stream #(
                .KERNEL_SIZE       (3),
                .INPUT_TILE_SIZE   (4),
                .INPUT_DATA_WIDTH  (8),
                .KERNEL_DATA_WIDTH (8),
                .CHANNELS          ((gi == 2) ? 3 : 1),
                .ACC_WIDTH         (AW),
                .RELU              ((gi == 1) ? 1 : 0)
            ) u_dut (
                .clk       (clk),
                .reset     (reset),
                .in_valid  (in_valid[gi]),
                .in_ready  (in_ready[gi]),
                .inpData   (inp_data[gi]),
                .Kernel    (kern[gi]),
                .flip      (flip_s[gi]),
                .out_valid (out_valid[gi]),
                .out_ready (out_ready[gi]),
                .outData   (out_data[gi]),
                .busy      (busy[gi])
            );
        end
    endgenerate

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint pix(input logic [4*AW-1:0] od, input int p);
        logic [AW-1:0] s;
        s = od[p*AW +: AW];
        return longint'($signed(s));
    endfunction

    function automatic logic [127:0] tile_seq();
        logic [127:0] t;
        t = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                t[(r*4+c)*8 +: 8] = 8'(4 * r + c + 1);
            end
        end
        return t;
    endfunction

    function automatic vec_t mk(input int d, input logic [127:0] t, input logic [71:0] k,
                                input logic f0, input logic fr, input int b,
                                input int e0, input int e1, input int e2, input int e3);
        vec_t v;
        v.dut = d; v.tile = t; v.kern = k; v.flip0 = f0; v.flip_rest = fr; v.beats = b;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
        return v;
    endfunction

    // Entered and left on a negedge; on return the accepting posedge has just passed.
    task automatic send_beat(input int d, input logic [127:0] t, input logic [71:0] k, input logic f);
        int w;
        w = 0;
        inp_data[d] = t; kern[d] = k; flip_s[d] = f; in_valid[d] = 1'b1;
        while (in_ready[d] !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        if (w >= 40) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout dut%0d: in_ready=%b, expected 1", d, in_ready[d]);
        end
        @(negedge clk);
        in_valid[d] = 1'b0;
    endtask

    task automatic wait_evt(input int d, output int k);
        k = 0;
        while (in_ready[d] !== 1'b1 && out_valid[d] !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   k;
        v = vt[idx];
        for (int b = 0; b < v.beats; b++) begin
            send_beat(v.dut, v.tile, v.kern, (b == 0) ? v.flip0 : v.flip_rest);
            check($sformatf("vec%0d_beat%0d_busy", idx, b), longint'(busy[v.dut]), 1);
            wait_evt(v.dut, k);
            check($sformatf("vec%0d_beat%0d_latency", idx, b), k, 9);
        end
        check($sformatf("vec%0d_out_valid", idx), longint'(out_valid[v.dut]), 1);
        for (int p = 0; p < 4; p++) begin
            check($sformatf("vec%0d_pix%0d", idx, p), pix(out_data[v.dut], p),
                  longint'($signed(v.exp[p])));
        end
        out_ready[v.dut] = 1'b1;
        @(negedge clk);
        out_ready[v.dut] = 1'b0;
        check($sformatf("vec%0d_out_valid_drop", idx), longint'(out_valid[v.dut]), 0);
        check($sformatf("vec%0d_in_ready_back", idx), longint'(in_ready[v.dut]), 1);
        $display("vector %0d dut%0d: pix = %0d %0d %0d %0d", idx, v.dut,
                 pix(out_data[v.dut], 0), pix(out_data[v.dut], 1),
                 pix(out_data[v.dut], 2), pix(out_data[v.dut], 3));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0]    t_seq;
        logic [127:0]    t_neg;
        logic [71:0]     k_one;
        logic [71:0]     k_w00;
        logic [4*AW-1:0] held;
        int              k;
        int              seen;

        t_seq = tile_seq();
        t_neg = {16{8'hFF}};
        k_one = {9{8'h01}};
        k_w00 = 72'h1;

        vt[0] = mk(0, t_seq, k_one, 1'b0, 1'b0, 1, 54, 63, 90, 99);
        vt[1] = mk(0, t_seq, k_w00, 1'b0, 1'b0, 1, 1, 2, 5, 6);
        vt[2] = mk(0, t_seq, k_w00, 1'b1, 1'b1, 1, 11, 12, 15, 16);
        vt[3] = mk(0, t_neg, k_one, 1'b0, 1'b0, 1, -9, -9, -9, -9);
        vt[4] = mk(1, t_neg, k_one, 1'b0, 1'b0, 1, 0, 0, 0, 0);
        vt[5] = mk(2, t_seq, k_one, 1'b0, 1'b0, 3, 162, 189, 270, 297);
        vt[6] = mk(1, t_seq, k_one, 1'b0, 1'b0, 1, 54, 63, 90, 99);
        vt[7] = mk(2, t_seq, k_w00, 1'b0, 1'b1, 3, 3, 6, 15, 18);
        vt[8] = mk(2, t_seq, k_w00, 1'b1, 1'b0, 3, 33, 36, 45, 48);

        for (int d = 0; d < NDUT; d++) begin
            in_valid[d] = 1'b0; inp_data[d] = '0; kern[d] = '0;
            flip_s[d] = 1'b0; out_ready[d] = 1'b0;
        end

        reset = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("rst_in_ready_dut%0d", d), longint'(in_ready[d]), 0);
            check($sformatf("rst_out_valid_dut%0d", d), longint'(out_valid[d]), 0);
            check($sformatf("rst_busy_dut%0d", d), longint'(busy[d]), 0);
            check($sformatf("rst_out_zero_dut%0d", d), (out_data[d] == '0) ? 1 : 0, 1);
        end
        reset = 1'b1;
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("release_in_ready_dut%0d", d), longint'(in_ready[d]), 1);
        end
        $display("reset sequence done");

        for (int i = 0; i < 9; i++) begin
            run_vec(i);
        end

        // Output held under backpressure, then released with a single out_ready pulse.
        send_beat(0, t_seq, k_one, 1'b0);
        wait_evt(0, k);
        check("stall_latency", k, 9);
        held = out_data[0];
        check("stall_pix0", pix(held, 0), 54);
        check("stall_pix3", pix(held, 3), 99);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("stall%0d_stable", c), (out_data[0] == held) ? 1 : 0, 1);
            check($sformatf("stall%0d_out_valid", c), longint'(out_valid[0]), 1);
            check($sformatf("stall%0d_in_ready", c), longint'(in_ready[0]), 0);
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        check("stall_release_out_valid", longint'(out_valid[0]), 0);
        check("stall_release_in_ready", longint'(in_ready[0]), 1);
        $display("stall sequence done");

        // Reset in the middle of the second channel's MAC discards the partial tile.
        send_beat(2, t_seq, k_one, 1'b0);
        wait_evt(2, k);
        check("midrst_beat0_latency", k, 9);
        send_beat(2, t_seq, k_one, 1'b0);
        repeat (4) @(negedge clk);
        check("midrst_busy_before", longint'(busy[2]), 1);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", longint'(out_valid[2]), 0);
        check("midrst_busy", longint'(busy[2]), 0);
        check("midrst_in_ready", longint'(in_ready[2]), 0);
        check("midrst_out_zero", (out_data[2] == '0) ? 1 : 0, 1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_release_in_ready", longint'(in_ready[2]), 1);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid[2] === 1'b1) seen++;
        end
        check("midrst_no_output", seen, 0);
        $display("mid-MAC reset sequence done");
        run_vec(5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
